// File: rtl/mult_controller_if.sv
// mult_controller_if: controller/datapath handshake bundle; abort signal present when MULT_CTRL_ABORT_EN is defined
interface mult_controller_if #(parameter int WIDTH = 4);
   localparam int CW = $clog2(WIDTH + 1);
   logic          start;
   logic          q0;
   logic          ld_regs;
   logic          add_en;
   logic          shift_en;
   logic          busy;
   logic          done;
   logic [CW-1:0] bit_cnt;
`ifdef MULT_CTRL_ABORT_EN
   logic          abort;
   modport master (output start, q0, abort, input ld_regs, add_en, shift_en, busy, done, bit_cnt);
   modport slave (input start, q0, abort, output ld_regs, add_en, shift_en, busy, done, bit_cnt);
`else
   modport master (output start, q0, input ld_regs, add_en, shift_en, busy, done, bit_cnt);
   modport slave (input start, q0, output ld_regs, add_en, shift_en, busy, done, bit_cnt);
`endif
endinterface

// File: rtl/mult_controller.sv
// mult_controller: shift-add multiplier control FSM; optional abort input enabled by MULT_CTRL_ABORT_EN
module mult_controller #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   mult_controller_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, LOAD, TEST, ADD, SHIFT, DONE} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_bit_cnt;

   // State register and iteration counter; counter advances on leaving SHIFT, clears on entering IDLE
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
      end else begin
         r_state   <= w_next;
         r_bit_cnt <= (w_next == IDLE) ? '0 : (r_state == SHIFT) ? r_bit_cnt + 1'b1 : r_bit_cnt;
      end
   end

   // Next-state logic plus Moore output decode from the state register only
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = bus.start ? LOAD : IDLE;
         LOAD:    w_next = TEST;
         TEST:    w_next = bus.q0 ? ADD : SHIFT;
         ADD:     w_next = SHIFT;
         SHIFT:   w_next = (r_bit_cnt == LAST) ? DONE : TEST;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
`ifdef MULT_CTRL_ABORT_EN
      if (bus.abort && r_state != IDLE) w_next = IDLE;
`endif
      bus.ld_regs  = (r_state == LOAD);
      bus.add_en   = (r_state == ADD);
      bus.shift_en = (r_state == SHIFT);
      bus.busy     = (r_state != IDLE);
      bus.done     = (r_state == DONE);
      bus.bit_cnt  = r_bit_cnt;
   end
endmodule

// File: tb/tb_mult_controller.sv
// tb_mult_controller: random and directed multiplies against a cycle-trace reference and a behavioural datapath
module tb_mult_controller;
   localparam int W  = 4;
   localparam int CW = $clog2(W + 1);
   localparam int VW = 5 + CW;
   localparam int C_I = 0, C_L = 1, C_T = 2, C_A = 3, C_S = 4, C_D = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   int           checks = 0;
   int           failures = 0;
   int           opn = 0;
   logic [W-1:0] op_mul = '0;
   logic [W-1:0] op_mcand = '0;
   logic [W:0]   dp_a;
   logic [W-1:0] dp_q;
   logic [W-1:0] dp_m;

   mult_controller_if #(.WIDTH(W)) m();

   mult_controller #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (m)
   );

   always #5 clk = ~clk;

   assign m.q0 = dp_q[0];

   // Behavioural shift-add datapath driven by the controller strobes
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_a <= '0;
         dp_q <= '0;
         dp_m <= '0;
      end else if (m.ld_regs) begin
         dp_a <= '0;
         dp_q <= op_mul;
         dp_m <= op_mcand;
      end else if (m.add_en) begin
         dp_a <= dp_a + {1'b0, dp_m};
      end else if (m.shift_en) begin
         {dp_a, dp_q} <= {dp_a, dp_q} >> 1;
      end
   end

   function automatic logic [VW-1:0] obs_vec();
      return {m.ld_regs, m.add_en, m.shift_en, m.busy, m.done, m.bit_cnt};
   endfunction

   function automatic logic [VW-1:0] exp_vec(input int code, input int cnt);
      logic [CW-1:0] c;
      c = (code == C_I) ? '0 : CW'(cnt);
      return {code == C_L, code == C_A, code == C_S, code != C_I, code == C_D, c};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [W-1:0] mul, input logic [W-1:0] mcand, input bit hold);
      int q[$];
      int ones = 0, cnt = 0, first_done = -1, n_ld = 0, n_add = 0, n_sh = 0;
      q.push_back(C_L);
      for (int i = 0; i < W; i++) begin
         q.push_back(C_T);
         if (mul[i]) begin
            q.push_back(C_A);
            ones++;
         end
         q.push_back(C_S);
      end
      q.push_back(C_D);
      q.push_back(C_I);
      opn++;
      op_mul   = mul;
      op_mcand = mcand;
      m.start  = 1'b1;
      @(posedge clk);
      for (int k = 0; k < q.size(); k++) begin
         @(negedge clk);
         if (!hold) m.start = 1'b0;
         chk($sformatf("op%0d_cyc%0d", opn, k), 32'(obs_vec()), 32'(exp_vec(q[k], cnt)));
         if (m.done && first_done < 0) begin
            first_done = k;
            chk($sformatf("op%0d_product", opn), 32'({dp_a[W-1:0], dp_q}), 32'(mul * mcand));
         end
         n_ld  += int'(m.ld_regs);
         n_add += int'(m.add_en);
         n_sh  += int'(m.shift_en);
         if (q[k] == C_S) cnt++;
      end
      chk($sformatf("op%0d_latency", opn), 32'(first_done + 1), 32'(2 + 2 * W + ones));
      chk($sformatf("op%0d_n_ld", opn), 32'(n_ld), 32'd1);
      chk($sformatf("op%0d_n_add", opn), 32'(n_add), 32'(ones));
      chk($sformatf("op%0d_n_shift", opn), 32'(n_sh), 32'(W));
   endtask

   initial begin
      int nsh, nadd, ndone;
      m.start = 1'b0;
`ifdef MULT_CTRL_ABORT_EN
      m.abort = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("in_reset", 32'(obs_vec()), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset", 32'(obs_vec()), 32'd0);
      run_op(4'b1011, 4'b0101, 1'b0);
      run_op(4'b0000, 4'(($urandom % 15) + 1), 1'b0);
      run_op(4'b1111, 4'b1111, 1'b0);
      for (int r = 0; r < 6; r++) run_op(4'($urandom), 4'($urandom), 1'b0);
      m.start = 1'b1;
      run_op(4'($urandom), 4'($urandom), 1'b1);
      run_op(4'($urandom), 4'($urandom), 1'b1);
      m.start = 1'b0;
      @(negedge clk);
      chk("hold_end_idle", 32'(obs_vec()), 32'd0);
      op_mul  = 4'b0101;
      m.start = 1'b1;
      @(posedge clk);
      nsh = 0;
      for (int k = 0; k < 20 && nsh < 2; k++) begin
         @(negedge clk);
         m.start = 1'b0;
         if (m.shift_en) nsh++;
      end
      chk("rst_reach_shift2", 32'(nsh), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("rst_async", 32'(obs_vec()), 32'd0);
      @(negedge clk);
      chk("rst_held", 32'(obs_vec()), 32'd0);
      rst_n = 1'b1;
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         ndone += int'(m.done) + int'(m.busy);
      end
      chk("rst_no_done", 32'(ndone), 32'd0);
`ifdef MULT_CTRL_ABORT_EN
      op_mul  = 4'b0110;
      m.start = 1'b1;
      @(posedge clk);
      nadd = 0;
      for (int k = 0; k < 20 && nadd < 1; k++) begin
         @(negedge clk);
         m.start = 1'b0;
         if (m.add_en) nadd++;
      end
      chk("abort_reach_add", 32'(nadd), 32'd1);
      m.abort = 1'b1;
      @(negedge clk);
      m.abort = 1'b0;
      chk("abort_idle", 32'(obs_vec()), 32'd0);
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         ndone += int'(m.done) + int'(m.busy);
      end
      chk("abort_no_done", 32'(ndone), 32'd0);
`else
      nadd = 0;
`endif
      run_op(4'($urandom), 4'($urandom), 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
